// File: rtl/seq_gen_pkg.sv
// Shared definitions for the seq_gen serial pattern transmitter and its seq_det partner:
// FSM state encoding and the default pattern.
package seq_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int SEQ_PAT_W = 4;
  localparam logic [SEQ_PAT_W-1:0] SEQ_PATTERN = 4'b1010;

endpackage

// File: rtl/seq_gen_ser.sv
// Pattern shift register and bit index for seq_gen. load restarts at the MSB, shift advances one bit.
// SEQ_GEN_SOF_EN adds the first_bit flag used to build the sof output.
module seq_gen_ser #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1010
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic shift,
  output logic bit_out,
`ifdef SEQ_GEN_SOF_EN
  output logic first_bit,
`endif
  output logic last_bit
);

  localparam int IDX_W = $clog2(PAT_W);

  logic [PAT_W-1:0] shreg;
  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      idx   <= '0;
    end else if (load) begin
      shreg <= PATTERN;
      idx   <= '0;
    end else if (shift) begin
      shreg <= {shreg[PAT_W-2:0], 1'b0};
      idx   <= idx + IDX_W'(1);
    end
  end

  assign bit_out  = shreg[PAT_W-1];
  assign last_bit = (idx == IDX_W'(PAT_W - 1));
`ifdef SEQ_GEN_SOF_EN
  assign first_bit = (idx == '0);
`endif

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter: sends PATTERN MSB-first rep_cnt times with GAP idle cycles between reps.
// Define SEQ_GEN_SOF_EN to add the sof output (high with the first bit of every repetition).
module seq_gen
  import seq_gen_pkg::*;
#(
  parameter int               PAT_W    = SEQ_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN  = SEQ_PATTERN,
  parameter int               CNT_W    = 4,
  parameter int               GAP      = 0,
  parameter logic             IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] rep_cnt,
  input  logic             abort,
  output logic             x,
  output logic             x_vld,
  output logic             busy,
  output logic             done,
  output state_t           dbg_state
`ifdef SEQ_GEN_SOF_EN
  ,
  output logic             sof
`endif
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rep_left;
  logic             load, shift, bit_out, last_bit, gap_last;
  logic             x_nxt, vld_nxt, busy_nxt, done_nxt;
`ifdef SEQ_GEN_SOF_EN
  logic             first_bit, sof_nxt;
`endif

  seq_gen_ser #(.PAT_W(PAT_W), .PATTERN(PATTERN)) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .shift    (shift),
    .bit_out  (bit_out),
`ifdef SEQ_GEN_SOF_EN
    .first_bit(first_bit),
`endif
    .last_bit (last_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // done is still high in the first IDLE cycle after DONE, so start is refused there as well.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    shift     = 1'b0;
    case (state)
      S_IDLE: if (start && !abort && !done) begin
        if (rep_cnt != '0) begin
          state_nxt = S_SEND;
          load      = 1'b1;
        end else begin
          state_nxt = S_DONE;
        end
      end
      S_SEND: if (abort) begin
        state_nxt = S_IDLE;
      end else if (last_bit) begin
        if (rep_left == CNT_W'(1)) state_nxt = S_DONE;
        else if (GAP == 0)         load      = 1'b1;
        else                       state_nxt = S_GAP;
      end else begin
        shift = 1'b1;
      end
      S_GAP: if (abort) begin
        state_nxt = S_IDLE;
      end else if (gap_last) begin
        state_nxt = S_SEND;
        load      = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)                                  rep_left <= '0;
    else if (state == S_IDLE && load)            rep_left <= rep_cnt;
    else if (state_nxt == S_IDLE)                rep_left <= '0;
    else if (state == S_SEND && last_bit && !abort && rep_left != CNT_W'(1))
                                                 rep_left <= rep_left - CNT_W'(1);
  end

  if (GAP > 0) begin : g_gap
    localparam int GAP_W = $clog2(GAP + 1);
    logic [GAP_W-1:0] gap_cnt;
    always_ff @(posedge clk) begin
      if (!rst_n)                                     gap_cnt <= '0;
      else if (state == S_GAP && !abort && !gap_last) gap_cnt <= gap_cnt + GAP_W'(1);
      else                                            gap_cnt <= '0;
    end
    assign gap_last = (gap_cnt == GAP_W'(GAP - 1));
  end else begin : g_no_gap
    assign gap_last = 1'b1;
  end

  // Outputs are registered views of the current state, so they trail the FSM by one cycle.
  always_comb begin
    x_nxt    = IDLE_BIT;
    vld_nxt  = 1'b0;
    busy_nxt = 1'b0;
    done_nxt = (state == S_DONE);
    if (!abort && state == S_SEND) begin
      x_nxt    = bit_out;
      vld_nxt  = 1'b1;
      busy_nxt = 1'b1;
    end
    if (!abort && state == S_GAP) busy_nxt = 1'b1;
`ifdef SEQ_GEN_SOF_EN
    sof_nxt = vld_nxt && first_bit;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x     <= IDLE_BIT;
      x_vld <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SEQ_GEN_SOF_EN
      sof   <= 1'b0;
`endif
    end else begin
      x     <= x_nxt;
      x_vld <= vld_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
`ifdef SEQ_GEN_SOF_EN
      sof   <= sof_nxt;
`endif
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_seq_gen.sv
// Bench for seq_gen: a GAP=0 and a GAP=2 instance share stimulus; a cycle model derived from
// the repetition/gap arithmetic is compared every cycle, plus literal bit streams and counts.
module tb_seq_gen;
  import seq_gen_pkg::*;

  localparam int PW = 4;
  localparam int CW = 4;
  localparam logic [PW-1:0] PAT = 4'b1010;
`ifdef SEQ_GEN_SOF_EN
  localparam bit SOF_EN = 1'b1;
`else
  localparam bit SOF_EN = 1'b0;
`endif

  // ---- clock / reset / DUTs ----
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [CW-1:0] rep_cnt = '0;
  logic x0, v0, b0, d0, x2, v2, b2, d2, sof0, sof2;
  state_t st0, st2;

  always #5 clk = ~clk;

  seq_gen #(.GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .rep_cnt(rep_cnt), .abort(abort),
    .x(x0), .x_vld(v0), .busy(b0), .done(d0), .dbg_state(st0)
`ifdef SEQ_GEN_SOF_EN
    , .sof(sof0)
`endif
  );

  seq_gen #(.GAP(2), .IDLE_BIT(1'b0)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .rep_cnt(rep_cnt), .abort(abort),
    .x(x2), .x_vld(v2), .busy(b2), .done(d2), .dbg_state(st2)
`ifdef SEQ_GEN_SOF_EN
    , .sof(sof2)
`endif
  );

`ifndef SEQ_GEN_SOF_EN
  assign sof0 = 1'b0;
  assign sof2 = 1'b0;
`endif

  int checks = 0, failures = 0;
  logic [0:0] exp_q[$];
  bit chk_en = 1'b0;
  int vld_cnt0, done_cnt0, busy_cnt0, sof_cnt0, vld_cnt2, done_cnt2, busy_cnt2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: output as a function of cycles since accept ----
  bit act_m[2];
  int t_m[2], n_m[2];

  function automatic int gap_of(int i);
    return (i == 0) ? 0 : 2;
  endfunction

  function automatic int total_of(int n, int gap);
    return (n == 0) ? 0 : n * PW + (n - 1) * gap;
  endfunction

  // {x, x_vld, busy, done, sof}; t=0 is the cycle right after the accepting edge.
  function automatic logic [4:0] expect_out(int t, int n, int gap);
    logic [PW-1:0] pat;
    int tot, r;
    pat = PAT;
    tot = total_of(n, gap);
    if (t >= 1 && t <= tot) begin
      r = (t - 1) % (PW + gap);
      if (r < PW) return {pat[PW-1-r], 1'b1, 1'b1, 1'b0, SOF_EN && (r == 0)};
      return 5'b00100;
    end
    if (t == tot + 1 && t > 0) return 5'b00010;
    return 5'b00000;
  endfunction

  function automatic logic [4:0] model_out(int i);
    return act_m[i] ? expect_out(t_m[i], n_m[i], gap_of(i)) : 5'b00000;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        act_m[i] = 1'b0;
      end else if (act_m[i]) begin
        if (t_m[i] == total_of(n_m[i], gap_of(i)) + 1) act_m[i] = 1'b0;
        else if (abort && t_m[i] + 1 <= total_of(n_m[i], gap_of(i))) act_m[i] = 1'b0;
        else t_m[i] = t_m[i] + 1;
      end else if (start && !abort) begin
        act_m[i] = 1'b1;
        t_m[i]   = 0;
        n_m[i]   = int'(rep_cnt);
      end
    end
  end

  // ---- compare process + scoreboard ----
  always @(negedge clk) begin
    if (chk_en) begin
      check("dut0_outputs", 32'({x0, v0, b0, d0, sof0}), 32'(model_out(0)));
      check("dut2_outputs", 32'({x2, v2, b2, d2, sof2}), 32'(model_out(1)));
      if (v0) begin
        if (exp_q.size() == 0) check("stream0_extra_bit", 32'(1), 32'(0));
        else check("stream0_bit", 32'(x0), 32'(exp_q.pop_front()));
      end
      vld_cnt0  += int'(v0);
      done_cnt0 += int'(d0);
      busy_cnt0 += int'(b0);
      sof_cnt0  += int'(sof0);
      vld_cnt2  += int'(v2);
      done_cnt2 += int'(d2);
      busy_cnt2 += int'(b2);
    end
  end

  // ---- driver tasks ----
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    vld_cnt0 = 0; done_cnt0 = 0; busy_cnt0 = 0; sof_cnt0 = 0;
    vld_cnt2 = 0; done_cnt2 = 0; busy_cnt2 = 0;
  endtask

  task automatic push_bits(input int n, input logic [15:0] bits);
    for (int i = n - 1; i >= 0; i--) exp_q.push_back(bits[i]);
  endtask

  task automatic send(input int n);
    start   = 1'b1;
    rep_cnt = CW'(n);
    tick();
    start   = 1'b0;
    rep_cnt = 4'hF;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((act_m[0] || act_m[1]) && n < 300) begin
      tick();
      n++;
    end
    check("wait_idle_bound", 32'(n < 300), 32'(1));
    tick();
  endtask

  // ---- directed tests ----
  initial begin
    clear_counts();
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    check("reset_outputs", 32'({x0, v0, b0, d0}), 32'(0));
    rst_n = 1'b1;
    tick();

    // single repetition, first bit one cycle after the accepting edge
    clear_counts();
    push_bits(4, 16'b1010);
    send(1);
    @(negedge clk);
    check("latency_no_vld_yet", 32'(v0), 32'(0));
    tick();
    @(negedge clk);
    check("latency_first_bit", 32'({x0, v0}), 32'(2'b11));
    wait_idle();
    check("single_done_cnt", 32'(done_cnt0), 32'(1));
    check("single_vld_cnt", 32'(vld_cnt0), 32'(4));

    // three reps: back-to-back on dut0, gapped on dut2
    clear_counts();
    push_bits(12, 16'b1010_1010_1010);
    send(3);
    wait_idle();
    check("rep3_vld_cnt0", 32'(vld_cnt0), 32'(12));
    check("rep3_busy_cnt0", 32'(busy_cnt0), 32'(12));
    check("rep3_done_cnt0", 32'(done_cnt0), 32'(1));
    check("rep3_vld_cnt2", 32'(vld_cnt2), 32'(12));
    check("rep3_busy_cnt2", 32'(busy_cnt2), 32'(16));
    if (SOF_EN) check("rep3_sof_cnt", 32'(sof_cnt0), 32'(3));

    // two reps: one 2-cycle gap on dut2, none after the final rep
    clear_counts();
    push_bits(8, 16'b1010_1010);
    send(2);
    wait_idle();
    check("rep2_vld_cnt2", 32'(vld_cnt2), 32'(8));
    check("rep2_busy_cnt2", 32'(busy_cnt2), 32'(10));
    check("rep2_done_cnt2", 32'(done_cnt2), 32'(1));

    // zero repetitions: done only
    clear_counts();
    send(0);
    wait_idle();
    check("rep0_done_cnt", 32'(done_cnt0), 32'(1));
    check("rep0_vld_cnt", 32'(vld_cnt0), 32'(0));
    check("rep0_busy_cnt", 32'(busy_cnt0), 32'(0));

    // start while busy is ignored
    clear_counts();
    push_bits(8, 16'b1010_1010);
    send(2);
    repeat (3) tick();
    start = 1'b1; rep_cnt = 4'd5;
    tick();
    start = 1'b0;
    wait_idle();
    check("busy_start_vld_cnt", 32'(vld_cnt0), 32'(8));
    check("busy_start_done_cnt", 32'(done_cnt0), 32'(1));

    // abort after two bits
    clear_counts();
    push_bits(2, 16'b10);
    send(3);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_vld_low", 32'({v0, b0}), 32'(0));
    wait_idle();
    check("abort_vld_cnt", 32'(vld_cnt0), 32'(2));
    check("abort_done_cnt", 32'(done_cnt0 + done_cnt2), 32'(0));

    // abort together with start in IDLE
    clear_counts();
    abort = 1'b1; start = 1'b1; rep_cnt = 4'd2;
    tick();
    abort = 1'b0; start = 1'b0;
    repeat (4) tick();
    check("abort_start_busy_cnt", 32'(busy_cnt0 + busy_cnt2), 32'(0));
    check("abort_start_done_cnt", 32'(done_cnt0), 32'(0));

    // reset for two cycles mid-SEND, then restart from the MSB
    clear_counts();
    push_bits(2, 16'b10);
    send(3);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("midreset_outputs", 32'({x0, v0, b0, d0}), 32'(0));
    check("midreset_vld_cnt", 32'(vld_cnt0), 32'(2));
    check("midreset_done_cnt", 32'(done_cnt0), 32'(0));
    clear_counts();
    push_bits(4, 16'b1010);
    send(1);
    wait_idle();
    check("restart_vld_cnt", 32'(vld_cnt0), 32'(4));
    check("restart_done_cnt", 32'(done_cnt0), 32'(1));

    check("stream0_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
